// File: rtl/apb_bridge_if.sv
// Bus-side request/response and APB completer signals of the bridge.
// 'slave' is the bridge's view; 'master' is the requester/completer side.
interface apb_bridge_if;
    logic        hsel_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] hwdata_i;
    logic [31:0] hrdata_o;
    logic        hready_o;
    logic        herr_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    modport slave (
        input  hsel_i, addr_i, we_i, hwdata_i, prdata_i, pready_i, pslverr_i,
        output hrdata_o, hready_o, herr_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );

    modport master (
        output hsel_i, addr_i, we_i, hwdata_i, prdata_i, pready_i, pslverr_i,
        input  hrdata_o, hready_o, herr_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
    );
endinterface

// File: rtl/apb_bridge.sv
// Single-outstanding bus-to-APB bridge with ACCESS-phase timeout.
// Every output comes straight from a flop; next values are computed in one comb block.
module apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    apb_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        hready_q, hready_d;
    logic        herr_q, herr_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            paddr_q   <= 32'h0;
            pwdata_q  <= 32'h0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            hrdata_q  <= 32'h0;
            hready_q  <= 1'b0;
            herr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hrdata_q  <= hrdata_d;
            hready_q  <= hready_d;
            herr_q    <= herr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        hrdata_d  = hrdata_q;
        // Response flags are single-cycle: they only rise on the edge into RESP.
        hready_d  = 1'b0;
        herr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.hsel_i) begin
                    paddr_d   = bus.addr_i;
                    pwrite_d  = bus.we_i;
                    pwdata_d  = bus.hwdata_i;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready completer beats a timeout landing in the same cycle.
                if (bus.pready_i) begin
                    state_d   = RESP;
                    hready_d  = 1'b1;
                    herr_d    = bus.pslverr_i;
                    hrdata_d  = (!pwrite_q && !bus.pslverr_i) ? bus.prdata_i : 32'h0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIMIT) begin
                        state_d   = RESP;
                        hready_d  = 1'b1;
                        herr_d    = 1'b1;
                        hrdata_d  = 32'h0;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.paddr_o   = paddr_q;
    assign bus.pwdata_o  = pwdata_q;
    assign bus.pwrite_o  = pwrite_q;
    assign bus.psel_o    = psel_q;
    assign bus.penable_o = penable_q;
    assign bus.hrdata_o  = hrdata_q;
    assign bus.hready_o  = hready_q;
    assign bus.herr_o    = herr_q;
endmodule

// File: tb/tb_apb_bridge.sv
// Bench for apb_bridge: behavioural completer plus scoreboard of expected responses.
module tb_apb_bridge;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [31:0] hrdata;
        logic        herr;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    apb_bridge_if bif();

    apb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer; b2b means hsel_i was already held through the previous RESP.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic err,
                        input logic b2b, input logic keep);
        exp_t e;
        exp_t got;
        int   acc;
        int   cyc;
        bit   done;
        e.acc    = (waits < TO) ? waits + 1 : TO;
        e.herr   = err || (waits >= TO);
        e.hrdata = (!we && !err && waits < TO) ? rdata : 32'h0;
        e.lat    = 2 + e.acc + (b2b ? 1 : 0);
        sb.push_back(e);
        bif.hsel_i   = 1'b1;
        bif.addr_i   = addr;
        bif.we_i     = we;
        bif.hwdata_i = wdata;
        acc  = 0;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bif.psel_o && !bif.penable_o) begin
                check("setup_paddr", bif.paddr_o, addr);
                // Scramble requester inputs: the latched copy must not follow.
                bif.addr_i   = ~addr;
                bif.hwdata_i = ~wdata;
                bif.we_i     = ~we;
            end
            if (bif.psel_o && bif.penable_o) begin
                check("acc_paddr", bif.paddr_o, addr);
                check("acc_pwdata", bif.pwdata_o, wdata);
                check("acc_pwrite", {31'h0, bif.pwrite_o}, {31'h0, we});
                bif.pready_i  = (acc == waits);
                bif.prdata_i  = rdata;
                bif.pslverr_i = err;
                acc++;
            end else begin
                bif.pready_i  = 1'b1;
                bif.pslverr_i = 1'b1;
                bif.prdata_i  = ~rdata;
            end
            if (bif.hready_o) begin
                done = 1;
                if (sb.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    check("hrdata", bif.hrdata_o, got.hrdata);
                    check("herr", {31'h0, bif.herr_o}, {31'h0, got.herr});
                    check("latency", cyc, got.lat);
                    check("acc_cycles", acc, got.acc);
                    check("resp_psel", {31'h0, bif.psel_o}, 32'h0);
                    check("resp_penable", {31'h0, bif.penable_o}, 32'h0);
                end
            end else begin
                check("herr_quiet", {31'h0, bif.herr_o}, 32'h0);
            end
        end
        if (!done) begin
            check("hready_wait", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (!keep) begin
            bif.hsel_i = 1'b0;
            @(negedge clk);
            check("hready_pulse", {31'h0, bif.hready_o}, 32'h0);
            check("herr_after", {31'h0, bif.herr_o}, 32'h0);
            check("hrdata_hold", bif.hrdata_o, e.hrdata);
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bif.hsel_i    = 1'b0;
        bif.addr_i    = 32'h0;
        bif.we_i      = 1'b0;
        bif.hwdata_i  = 32'h0;
        bif.prdata_i  = 32'h0;
        bif.pready_i  = 1'b0;
        bif.pslverr_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_psel", {31'h0, bif.psel_o}, 32'h0);
        check("rst_penable", {31'h0, bif.penable_o}, 32'h0);
        check("rst_pwrite", {31'h0, bif.pwrite_o}, 32'h0);
        check("rst_hready", {31'h0, bif.hready_o}, 32'h0);
        check("rst_herr", {31'h0, bif.herr_o}, 32'h0);
        check("rst_paddr", bif.paddr_o, 32'h0);
        check("rst_pwdata", bif.pwdata_o, 32'h0);
        check("rst_hrdata", bif.hrdata_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        xfer(1'b0, 32'h4000_D004, 32'h0,         32'hA5A5_0001, 0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 32'h4000_0020, 32'hDEAD_BEEF, 32'h5555_AAAA, 2, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 32'h4000_0030, 32'h0,         32'h1234_5678, 0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 32'h4000_0040, 32'h0,         32'hCAFE_0004, 4, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 32'h4000_0044, 32'h0,         32'hCAFE_0003, 3, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 32'h4000_0048, 32'h0BAD_F00D, 32'h0,         1, 1'b1, 1'b0, 1'b0);
        // Back-to-back reads with hsel_i held high across RESP.
        xfer(1'b0, 32'h4000_0100, 32'h0,         32'h1111_2222, 0, 1'b0, 1'b0, 1'b1);
        xfer(1'b0, 32'h4000_0104, 32'h0,         32'h3333_4444, 1, 1'b0, 1'b1, 1'b0);

        // Reset asserted mid-ACCESS.
        bif.hsel_i   = 1'b1;
        bif.addr_i   = 32'h4000_0200;
        bif.we_i     = 1'b0;
        bif.pready_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_penable", {31'h0, bif.penable_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_acc_psel", {31'h0, bif.psel_o}, 32'h0);
        check("rst_acc_penable", {31'h0, bif.penable_o}, 32'h0);
        check("rst_acc_hready", {31'h0, bif.hready_o}, 32'h0);
        bif.hsel_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_hready", {31'h0, bif.hready_o}, 32'h0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", {31'h0, bif.psel_o}, 32'h0);
            check("post_rst_no_hready", {31'h0, bif.hready_o}, 32'h0);
        end
        xfer(1'b0, 32'h4000_0300, 32'h0, 32'h7777_8888, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = $urandom;
            d = $urandom;
            xfer(1'($urandom_range(0, 1)), a, d, ~d, int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
